id_ex_operand_stage: RTL and testbench

- Operand-delivery stage directly upstream of the 32-bit ALU: holds the 32x32 architectural register file and the ID/EX pipeline register.
- Reads rs/rt, applies the write-back bypass, selects register or extended immediate for the second operand, and registers src1/src2/ctrl/shamt for the ALU one cycle later.
- Write-back port is driven by the downstream WB stage.

---
 rtl/id_ex_operand_stage_pkg.sv | 26 ++
 rtl/reg_file_2r1w.sv | 50 +++++
 rtl/id_ex_operand_stage.sv | 87 ++++++++
 tb/tb_id_ex_operand_stage.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_operand_stage_pkg.sv
// Shared constants for the ID/EX operand stage: widths, ALU control codes
// and the encoding used for an empty (bubble) ID/EX slot.
package id_ex_operand_stage_pkg;

    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 5;
    localparam int CTRL_W  = 4;
    localparam int REG_N   = 1 << ADDR_W;
    localparam int IMM_W   = 16;
    localparam int SHAMT_W = 5;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_BEQ  = 4'b0011;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_BNE  = 4'b1001;
    localparam logic [3:0] ALU_LUI  = 4'b1011;
    localparam logic [3:0] ALU_SRA  = 4'b1110;
    localparam logic [3:0] ALU_SRAV = 4'b1111;

    // A bubble carries no valid bit, no write enable and all-zero fields.
    localparam logic [3:0] CTRL_BUBBLE = ALU_AND;

endpackage

// File: rtl/reg_file_2r1w.sv
// 2-read/1-write architectural register file with $0 hardwired to zero and
// write-back-to-read bypass so a same-cycle write is visible to the readers.
module reg_file_2r1w #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_b
);

    localparam int REG_N = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [REG_N];
    logic              wr_en;

    assign wr_en = we && (waddr != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_N; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[waddr] <= wdata;
        end
    end

    // Write-before-read: a write landing this cycle is returned directly.
    always_comb begin
        rdata_a = '0;
        if (raddr_a != '0) begin
            rdata_a = (wr_en && waddr == raddr_a) ? wdata : mem[raddr_a];
        end
    end

    always_comb begin
        rdata_b = '0;
        if (raddr_b != '0) begin
            rdata_b = (wr_en && waddr == raddr_b) ? wdata : mem[raddr_b];
        end
    end

endmodule

// File: rtl/id_ex_operand_stage.sv
// Operand-delivery stage ahead of the ALU: register file read with WB bypass,
// immediate extension, src2 selection and the ID/EX pipeline register.
module id_ex_operand_stage #(
    parameter int DATA_W = id_ex_operand_stage_pkg::DATA_W,
    parameter int ADDR_W = id_ex_operand_stage_pkg::ADDR_W,
    parameter int CTRL_W = id_ex_operand_stage_pkg::CTRL_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              id_valid_i,
    input  logic [ADDR_W-1:0] rs_addr_i,
    input  logic [ADDR_W-1:0] rt_addr_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    input  logic [15:0]       imm_i,
    input  logic [4:0]        shamt_i,
    input  logic [CTRL_W-1:0] alu_ctrl_i,
    input  logic              alu_src_i,
    input  logic              imm_zext_i,
    input  logic              reg_write_i,
    input  logic              wb_we_i,
    input  logic [ADDR_W-1:0] wb_addr_i,
    input  logic [DATA_W-1:0] wb_data_i,
    output logic              ex_valid_o,
    output logic [DATA_W-1:0] src1_o,
    output logic [DATA_W-1:0] src2_o,
    output logic [DATA_W-1:0] rt_data_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [4:0]        shamt_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    output logic              reg_write_o
);

    import id_ex_operand_stage_pkg::*;

    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W-1:0] src2_sel;

    reg_file_2r1w #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_reg_file (
        .clk     (clk_i),
        .rst_n   (rst_i),
        .we      (wb_we_i),
        .waddr   (wb_addr_i),
        .wdata   (wb_data_i),
        .raddr_a (rs_addr_i),
        .rdata_a (rs_data),
        .raddr_b (rt_addr_i),
        .rdata_b (rt_data)
    );

    // lui's 16-bit shift happens in the ALU, so only extension is done here.
    assign imm_ext  = imm_zext_i ? {{(DATA_W-16){1'b0}}, imm_i}
                                 : {{(DATA_W-16){imm_i[15]}}, imm_i};
    assign src2_sel = alu_src_i ? imm_ext : rt_data;

    // Slot control: flush_i forces a bubble (beats stall_i), stall_i holds
    // every field, otherwise the slot loads the current ID inputs and is
    // valid only when id_valid_i is set.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i || flush_i) begin
            ex_valid_o  <= 1'b0;
            reg_write_o <= 1'b0;
            src1_o      <= '0;
            src2_o      <= '0;
            rt_data_o   <= '0;
            ctrl_o      <= CTRL_W'(CTRL_BUBBLE);
            shamt_o     <= '0;
            rd_addr_o   <= '0;
        end else if (!stall_i) begin
            ex_valid_o  <= id_valid_i;
            reg_write_o <= reg_write_i & id_valid_i;
            src1_o      <= rs_data;
            src2_o      <= src2_sel;
            rt_data_o   <= rt_data;
            ctrl_o      <= alu_ctrl_i;
            shamt_o     <= shamt_i;
            rd_addr_o   <= rd_addr_i;
        end
    end

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Randomized scoreboard bench for id_ex_operand_stage with a behavioural
// register-file/slot model.
module tb_id_ex_operand_stage;
    import id_ex_operand_stage_pkg::*;

    localparam int EXP_W = 1 + 1 + 32 + 32 + 32 + 4 + 5 + 5;

    typedef struct packed {
        logic        stall;
        logic        flush;
        logic        id_valid;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [15:0] imm;
        logic [4:0]  shamt;
        logic [3:0]  ctrl;
        logic        alu_src;
        logic        imm_zext;
        logic        reg_write;
        logic        wb_we;
        logic [4:0]  wb_addr;
        logic [31:0] wb_data;
    } stim_t;

    logic        clk;
    logic        rst_i;
    logic        stall_i, flush_i, id_valid_i;
    logic [4:0]  rs_addr_i, rt_addr_i, rd_addr_i;
    logic [15:0] imm_i;
    logic [4:0]  shamt_i;
    logic [3:0]  alu_ctrl_i;
    logic        alu_src_i, imm_zext_i, reg_write_i;
    logic        wb_we_i;
    logic [4:0]  wb_addr_i;
    logic [31:0] wb_data_i;
    logic        ex_valid_o;
    logic [31:0] src1_o, src2_o, rt_data_o;
    logic [3:0]  ctrl_o;
    logic [4:0]  shamt_o;
    logic [4:0]  rd_addr_o;
    logic        reg_write_o;

    logic [EXP_W-1:0] exp_q[$];
    logic [31:0]      m_rf [32];
    logic [EXP_W-1:0] m_slot;
    int               n_tests;
    int               n_fail;

    id_ex_operand_stage dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .stall_i     (stall_i),
        .flush_i     (flush_i),
        .id_valid_i  (id_valid_i),
        .rs_addr_i   (rs_addr_i),
        .rt_addr_i   (rt_addr_i),
        .rd_addr_i   (rd_addr_i),
        .imm_i       (imm_i),
        .shamt_i     (shamt_i),
        .alu_ctrl_i  (alu_ctrl_i),
        .alu_src_i   (alu_src_i),
        .imm_zext_i  (imm_zext_i),
        .reg_write_i (reg_write_i),
        .wb_we_i     (wb_we_i),
        .wb_addr_i   (wb_addr_i),
        .wb_data_i   (wb_data_i),
        .ex_valid_o  (ex_valid_o),
        .src1_o      (src1_o),
        .src2_o      (src2_o),
        .rt_data_o   (rt_data_o),
        .ctrl_o      (ctrl_o),
        .shamt_o     (shamt_o),
        .rd_addr_o   (rd_addr_o),
        .reg_write_o (reg_write_o)
    );

    // clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [EXP_W-1:0] dut_out();
        return {ex_valid_o, reg_write_o, src1_o, src2_o, rt_data_o,
                ctrl_o, shamt_o, rd_addr_o};
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        return s;
    endfunction

    // reference model: value a reader sees this cycle
    function automatic logic [31:0] m_read(input logic [4:0] a, input stim_t s);
        if (a == 5'd0) return 32'd0;
        if (s.wb_we && s.wb_addr == a) return s.wb_data;
        return m_rf[a];
    endfunction

    function automatic logic [31:0] m_imm(input stim_t s);
        if (s.imm_zext || s.imm < 16'h8000) return 32'(s.imm);
        return 32'hFFFF_0000 + 32'(s.imm);
    endfunction

    task automatic drive(input stim_t s);
        stall_i     = s.stall;
        flush_i     = s.flush;
        id_valid_i  = s.id_valid;
        rs_addr_i   = s.rs;
        rt_addr_i   = s.rt;
        rd_addr_i   = s.rd;
        imm_i       = s.imm;
        shamt_i     = s.shamt;
        alu_ctrl_i  = s.ctrl;
        alu_src_i   = s.alu_src;
        imm_zext_i  = s.imm_zext;
        reg_write_i = s.reg_write;
        wb_we_i     = s.wb_we;
        wb_addr_i   = s.wb_addr;
        wb_data_i   = s.wb_data;
    endtask

    // drive, predict the slot after the coming edge, then commit the WB write
    task automatic apply(input stim_t s);
        logic [31:0] a, b;
        drive(s);
        a = m_read(s.rs, s);
        b = m_read(s.rt, s);
        if (s.flush) m_slot = '0;
        else if (!s.stall)
            m_slot = {s.id_valid, s.reg_write & s.id_valid, a,
                      s.alu_src ? m_imm(s) : b, b, s.ctrl, s.shamt, s.rd};
        exp_q.push_back(m_slot);
        if (s.wb_we && s.wb_addr != 5'd0) m_rf[s.wb_addr] = s.wb_data;
    endtask

    task automatic issue(input stim_t s);
        @(posedge clk);
        #2;
        apply(s);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_i = 1'b0;
        drive(idle());
        #1;
        n_tests++;
        if (dut_out() !== '0) begin
            n_fail++;
            $display("FAIL reset_async: got %h want 0", dut_out());
        end
        for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
        m_slot = '0;
        exp_q.push_back(m_slot);
        @(posedge clk);
        #2;
        rst_i = 1'b1;
        apply(idle());
    endtask

    function automatic stim_t rand_stim();
        stim_t s;
        s.stall     = ($urandom_range(0, 7) == 0);
        s.flush     = ($urandom_range(0, 9) == 0);
        s.id_valid  = ($urandom_range(0, 3) != 0);
        s.rs        = 5'($urandom_range(0, 7));
        s.rt        = 5'($urandom_range(0, 7));
        s.rd        = 5'($urandom_range(0, 31));
        s.imm       = 16'($urandom);
        s.shamt     = 5'($urandom_range(0, 31));
        s.ctrl      = 4'($urandom_range(0, 15));
        s.alu_src   = 1'($urandom_range(0, 1));
        s.imm_zext  = 1'($urandom_range(0, 1));
        s.reg_write = 1'($urandom_range(0, 1));
        s.wb_we     = 1'($urandom_range(0, 1));
        s.wb_addr   = 5'($urandom_range(0, 7));
        s.wb_data   = $urandom;
        return s;
    endfunction

    // scoreboard monitor: one expected slot per cycle, checked after the edge
    initial begin
        logic [EXP_W-1:0] exp_v;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                exp_v = exp_q.pop_front();
                n_tests++;
                if (dut_out() !== exp_v) begin
                    n_fail++;
                    $display("FAIL slot @%0t: got %h want %h", $time, dut_out(), exp_v);
                end
            end
        end
    end

    initial begin
        stim_t s;
        n_tests = 0;
        n_fail  = 0;
        rst_i   = 1'b0;
        m_slot  = '0;
        drive(idle());
        do_reset();

        // write $5, then read it
        s = idle(); s.wb_we = 1; s.wb_addr = 5; s.wb_data = 32'h1234_5678;
        issue(s);
        s = idle(); s.id_valid = 1; s.rs = 5; s.ctrl = ALU_ADD; s.rd = 3; s.reg_write = 1;
        issue(s);

        // same-cycle bypass on both ports, and $0 stays zero
        s = idle(); s.id_valid = 1; s.rs = 7; s.rt = 7; s.ctrl = ALU_SUB;
        s.wb_we = 1; s.wb_addr = 7; s.wb_data = 32'hDEAD_BEEF;
        issue(s);
        s = idle(); s.id_valid = 1; s.rs = 0; s.rt = 0;
        s.wb_we = 1; s.wb_addr = 0; s.wb_data = 32'hFFFF_FFFF;
        issue(s);

        // immediate extension, rt_data still carries reg[rt]
        s = idle(); s.id_valid = 1; s.rt = 5; s.imm = 16'h8001; s.alu_src = 1;
        s.ctrl = ALU_LUI;
        issue(s);
        s.imm_zext = 1;
        issue(s);

        // three held cycles; a WB write during the stall must still land
        s = idle(); s.id_valid = 1; s.rs = 7; s.rt = 5; s.ctrl = ALU_SLT;
        s.shamt = 9; s.rd = 12; s.reg_write = 1;
        issue(s);
        for (int i = 0; i < 3; i++) begin
            s = rand_stim(); s.stall = 1; s.flush = 0;
            s.wb_we = 1; s.wb_addr = 5'(9 + i); s.wb_data = $urandom;
            issue(s);
        end
        s = idle(); s.id_valid = 1; s.rs = 9; s.rt = 11; s.ctrl = ALU_OR;
        issue(s);

        // flush beats stall
        s = rand_stim(); s.stall = 1; s.flush = 1; s.id_valid = 1; s.reg_write = 1;
        issue(s);

        // invalid instruction loads fields but no valid/write
        s = idle(); s.id_valid = 0; s.reg_write = 1; s.rs = 7; s.rd = 4;
        s.ctrl = ALU_SRAV;
        issue(s);

        for (int i = 0; i < 400; i++) issue(rand_stim());

        // mid-run reset wipes the register file
        do_reset();
        for (int i = 1; i < 32; i++) begin
            s = idle(); s.id_valid = 1; s.rs = 5'(i); s.rt = 5'(32 - i);
            issue(s);
        end

        for (int i = 0; i < 200; i++) issue(rand_stim());
        s = idle();
        issue(s);

        repeat (3) @(posedge clk);
        #2;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
